// File: rtl/rv_bp_pkg.sv
// Shared branch-prediction definitions.
// Holds the 2-bit saturating counter encoding, the counter values used at
// reset and on allocation, and the saturating counter update helper.
// No ports: imported by the BTB storage array and the branch target unit.
package rv_bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_t;

  localparam ctr_t CTR_RESET = WNT;
  localparam ctr_t CTR_ALLOC = WT;

  // Step toward "taken" or "not taken", clamping at the strong states.
  function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
    if (taken)
      return (ctr == ST) ? ST : ctr_t'(ctr + 2'd1);
    else
      return (ctr == SNT) ? SNT : ctr_t'(ctr - 2'd1);
  endfunction

endpackage

// File: rtl/branch_target_unit_if.sv
// Pipeline-facing bundle of the branch target unit.
// Fetch side: f_pc in, f_hit/f_pred_taken/f_pred_target out.
// Execute side: e_valid, type flags, e_cond, e_pc, e_imm, e_rs1 and the
// carried prediction in; e_target out.
// Redirect side: redirect_valid/redirect_pc out to the PC mux.
// master = pipeline (drives inputs), slave = branch_target_unit.
interface branch_target_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] f_pc;
  logic            f_hit;
  logic            f_pred_taken;
  logic [XLEN-1:0] f_pred_target;

  logic            e_valid;
  logic            e_is_branch;
  logic            e_is_jal;
  logic            e_is_jalr;
  logic            e_cond;
  logic [XLEN-1:0] e_pc;
  logic [XLEN-1:0] e_imm;
  logic [XLEN-1:0] e_rs1;
  logic            e_pred_taken;
  logic [XLEN-1:0] e_pred_target;
  logic [XLEN-1:0] e_target;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output f_pc, e_valid, e_is_branch, e_is_jal, e_is_jalr, e_cond,
           e_pc, e_imm, e_rs1, e_pred_taken, e_pred_target,
    input  f_hit, f_pred_taken, f_pred_target, e_target,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  f_pc, e_valid, e_is_branch, e_is_jal, e_is_jalr, e_cond,
           e_pc, e_imm, e_rs1, e_pred_taken, e_pred_target,
    output f_hit, f_pred_taken, f_pred_target, e_target,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/btb_array.sv
// Direct-mapped branch target buffer storage.
// Ports: clk, rst (async, active-high; clears valid bits and counters),
// f_* asynchronous read used by Fetch, e_* asynchronous read of the
// valid/tag/counter fields used to resolve hits in Execute, w_* single
// synchronous write port.
module btb_array
  import rv_bp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int TAG_W = XLEN - IDX_W - 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] f_idx,
  output logic             f_valid,
  output logic [TAG_W-1:0] f_tag,
  output logic [XLEN-1:0]  f_target,
  output logic             f_jump,
  output ctr_t             f_ctr,
  input  logic [IDX_W-1:0] e_idx,
  output logic             e_valid,
  output logic [TAG_W-1:0] e_tag,
  output ctr_t             e_ctr,
  input  logic             we,
  input  logic [IDX_W-1:0] w_idx,
  input  logic [TAG_W-1:0] w_tag,
  input  logic [XLEN-1:0]  w_target,
  input  logic             w_jump,
  input  ctr_t             w_ctr
);

  logic             valid_q  [DEPTH];
  ctr_t             ctr_q    [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [XLEN-1:0]  target_q [DEPTH];
  logic             jump_q   [DEPTH];

  // Valid bits and counters carry the reset state; an async reset
  // invalidates the whole table immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_RESET;
      end
    end else if (we) begin
      valid_q[w_idx] <= 1'b1;
      ctr_q[w_idx]   <= w_ctr;
    end
  end

  // Payload fields are only meaningful behind a valid bit, so no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[w_idx]    <= w_tag;
      target_q[w_idx] <= w_target;
      jump_q[w_idx]   <= w_jump;
    end
  end

  assign f_valid  = valid_q[f_idx];
  assign f_tag    = tag_q[f_idx];
  assign f_target = target_q[f_idx];
  assign f_jump   = jump_q[f_idx];
  assign f_ctr    = ctr_q[f_idx];

  assign e_valid  = valid_q[e_idx];
  assign e_tag    = tag_q[e_idx];
  assign e_ctr    = ctr_q[e_idx];

endmodule

// File: rtl/branch_target_unit.sv
// Branch target unit: Execute-stage target computation, BTB update with
// 2-bit counters, same-cycle Fetch prediction and registered mispredict
// redirect.
// Ports: clk, rst (async, active-high), bus (slave side of
// branch_target_unit_if carrying the Fetch, Execute and redirect signals).
module branch_target_unit
  import rv_bp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
) (
  input logic                 clk,
  input logic                 rst,
  branch_target_unit_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag_in, e_tag_in;
  logic             f_rd_valid, f_rd_jump, e_rd_valid;
  logic [TAG_W-1:0] f_rd_tag, e_rd_tag;
  logic [XLEN-1:0]  f_rd_target;
  ctr_t             f_rd_ctr, e_rd_ctr, w_ctr;
  logic             f_hit, e_hit, cf, actual_taken, mispredict, we, w_jump;
  logic [XLEN-1:0]  target, jalr_sum, pc_plus4;
  logic             unused_pc_lsbs;

  assign f_idx    = bus.f_pc[IDX_W+1:2];
  assign f_tag_in = bus.f_pc[XLEN-1:IDX_W+2];
  assign e_idx    = bus.e_pc[IDX_W+1:2];
  assign e_tag_in = bus.e_pc[XLEN-1:IDX_W+2];
  assign unused_pc_lsbs = ^bus.f_pc[1:0];

  btb_array #(
    .XLEN (XLEN),
    .DEPTH(DEPTH),
    .IDX_W(IDX_W),
    .TAG_W(TAG_W)
  ) u_btb (
    .clk     (clk),
    .rst     (rst),
    .f_idx   (f_idx),
    .f_valid (f_rd_valid),
    .f_tag   (f_rd_tag),
    .f_target(f_rd_target),
    .f_jump  (f_rd_jump),
    .f_ctr   (f_rd_ctr),
    .e_idx   (e_idx),
    .e_valid (e_rd_valid),
    .e_tag   (e_rd_tag),
    .e_ctr   (e_rd_ctr),
    .we      (we),
    .w_idx   (e_idx),
    .w_tag   (e_tag_in),
    .w_target(target),
    .w_jump  (w_jump),
    .w_ctr   (w_ctr)
  );

  // Fetch prediction sees the table contents before any same-cycle write.
  assign f_hit             = f_rd_valid && (f_rd_tag == f_tag_in);
  assign bus.f_hit         = f_hit;
  assign bus.f_pred_taken  = f_hit && (f_rd_jump || f_rd_ctr[1]);
  assign bus.f_pred_target = f_hit ? f_rd_target : '0;

  // JALR clears bit 0 of the register-relative sum; carries wrap freely.
  always_comb begin
    jalr_sum    = bus.e_rs1 + bus.e_imm;
    jalr_sum[0] = 1'b0;
    target      = bus.e_is_jalr ? jalr_sum : (bus.e_pc + bus.e_imm);
  end

  assign bus.e_target = target;
  assign pc_plus4     = bus.e_pc + XLEN'(4);

  assign cf           = bus.e_valid & (bus.e_is_branch | bus.e_is_jal | bus.e_is_jalr);
  assign actual_taken = bus.e_is_jal | bus.e_is_jalr | (bus.e_is_branch & bus.e_cond);
  assign mispredict   = cf && ((actual_taken != bus.e_pred_taken) ||
                               (actual_taken && (bus.e_pred_target != target)));

  // Hits always refresh the entry; misses only allocate when taken.
  // Jump entries are pinned at strongly-taken.
  always_comb begin
    e_hit  = e_rd_valid && (e_rd_tag == e_tag_in);
    we     = cf && (e_hit || actual_taken);
    w_jump = bus.e_is_jal | bus.e_is_jalr;
    if (w_jump)
      w_ctr = ST;
    else if (e_hit)
      w_ctr = sat_update(e_rd_ctr, actual_taken);
    else
      w_ctr = CTR_ALLOC;
  end

  // Redirect pulses for exactly one cycle per mispredict; the PC is only
  // reloaded on a mispredict so it holds between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
    end else begin
      bus.redirect_valid <= mispredict;
      if (mispredict)
        bus.redirect_pc <= actual_taken ? target : pc_plus4;
    end
  end

endmodule

// File: tb/tb_branch_target_unit.sv
// Directed self-checking bench for branch_target_unit (XLEN=32, DEPTH=16).
module tb_branch_target_unit;

  logic clk;
  logic rst;
  int   compareCount;
  int   mismatchCount;

  branch_target_unit_if #(.XLEN(32)) bus ();

  branch_target_unit #(.XLEN(32), .DEPTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic br, input logic jal,
                               input logic jalr, input logic cond,
                               input logic [31:0] pc, input logic [31:0] imm,
                               input logic [31:0] rs1, input logic ptaken,
                               input logic [31:0] ptarget);
    bus.e_valid       = v;
    bus.e_is_branch   = br;
    bus.e_is_jal      = jal;
    bus.e_is_jalr     = jalr;
    bus.e_cond        = cond;
    bus.e_pc          = pc;
    bus.e_imm         = imm;
    bus.e_rs1         = rs1;
    bus.e_pred_taken  = ptaken;
    bus.e_pred_target = ptarget;
    #1;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic lookup(input logic [31:0] pc);
    bus.f_pc = pc;
    #1;
  endtask

  task automatic clockStep();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst           = 1'b1;
    bus.f_pc      = 32'h100;
    applyIdle();
    #10;
    rst = 1'b0;
    #1;

    // Reset state
    checkOutput("rst_f_hit", 32'(bus.f_hit), 32'h0);
    checkOutput("rst_f_pred_taken", 32'(bus.f_pred_taken), 32'h0);
    checkOutput("rst_f_pred_target", bus.f_pred_target, 32'h0);
    checkOutput("rst_redirect_valid", 32'(bus.redirect_valid), 32'h0);
    checkOutput("rst_redirect_pc", bus.redirect_pc, 32'h0);

    // Taken BEQ, predicted not-taken: allocate and redirect to 0x140
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h40, 32'h0, 1'b0, 32'h0);
    checkOutput("beq_e_target", bus.e_target, 32'h140);
    checkOutput("beq_prewrite_f_hit", 32'(bus.f_hit), 32'h0);
    clockStep();
    checkOutput("beq_redirect_valid", 32'(bus.redirect_valid), 32'h1);
    checkOutput("beq_redirect_pc", bus.redirect_pc, 32'h140);
    checkOutput("beq_f_hit", 32'(bus.f_hit), 32'h1);
    checkOutput("beq_f_pred_taken", 32'(bus.f_pred_taken), 32'h1);
    checkOutput("beq_f_pred_target", bus.f_pred_target, 32'h140);

    // Same BEQ not taken twice, predicted taken: counter 2->1->0
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h40, 32'h0, 1'b1, 32'h140);
    clockStep();
    checkOutput("nt1_redirect_valid", 32'(bus.redirect_valid), 32'h1);
    checkOutput("nt1_redirect_pc", bus.redirect_pc, 32'h104);
    checkOutput("nt1_f_pred_taken", 32'(bus.f_pred_taken), 32'h0);
    clockStep();
    checkOutput("nt2_redirect_valid", 32'(bus.redirect_valid), 32'h1);
    checkOutput("nt2_redirect_pc", bus.redirect_pc, 32'h104);
    checkOutput("nt2_f_hit", 32'(bus.f_hit), 32'h1);
    checkOutput("nt2_f_pred_taken", 32'(bus.f_pred_taken), 32'h0);

    // Counter must now sit at 0: one taken step only reaches 1 (still not-taken)
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h40, 32'h0, 1'b0, 32'h0);
    clockStep();
    checkOutput("sat_f_pred_taken", 32'(bus.f_pred_taken), 32'h0);

    // Idle slot: pulse drops, redirect_pc holds
    applyIdle();
    clockStep();
    checkOutput("idle_redirect_valid", 32'(bus.redirect_valid), 32'h0);
    checkOutput("idle_redirect_pc", bus.redirect_pc, 32'h140);

    // JALR with a wrong predicted target
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200, 32'h4, 32'h2001, 1'b1, 32'h3000);
    checkOutput("jalr_e_target", bus.e_target, 32'h2004);
    clockStep();
    checkOutput("jalr_redirect_valid", 32'(bus.redirect_valid), 32'h1);
    checkOutput("jalr_redirect_pc", bus.redirect_pc, 32'h2004);
    lookup(32'h200);
    checkOutput("jalr_f_pred_taken", 32'(bus.f_pred_taken), 32'h1);
    checkOutput("jalr_f_pred_target", bus.f_pred_target, 32'h2004);

    // Correctly predicted JALR: no redirect, pc holds
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200, 32'h4, 32'h2001, 1'b1, 32'h2004);
    clockStep();
    checkOutput("jalr_ok_redirect_valid", 32'(bus.redirect_valid), 32'h0);
    checkOutput("jalr_ok_redirect_pc", bus.redirect_pc, 32'h2004);

    // Address wrap: 0xFFFFFFF0 + 0x20 = 0x10
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h20, 32'h0, 1'b0, 32'h0);
    checkOutput("wrap_e_target", bus.e_target, 32'h10);
    clockStep();
    checkOutput("wrap_redirect_valid", 32'(bus.redirect_valid), 32'h1);
    checkOutput("wrap_redirect_pc", bus.redirect_pc, 32'h10);
    lookup(32'hFFFF_FFF0);
    checkOutput("wrap_f_pred_target", bus.f_pred_target, 32'h10);

    // Alias at 0xFFFFFFF0 + 64 = 0x30 (same index 12), back-to-back mispredict
    lookup(32'h30);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h30, 32'h20, 32'h0, 1'b0, 32'h0);
    checkOutput("alias_prewrite_f_hit", 32'(bus.f_hit), 32'h0);
    clockStep();
    checkOutput("alias_redirect_valid", 32'(bus.redirect_valid), 32'h1);
    checkOutput("alias_redirect_pc", bus.redirect_pc, 32'h50);
    checkOutput("alias_new_f_target", bus.f_pred_target, 32'h50);
    lookup(32'hFFFF_FFF0);
    checkOutput("alias_old_f_hit", 32'(bus.f_hit), 32'h0);
    checkOutput("alias_old_f_target", bus.f_pred_target, 32'h0);

    // Asynchronous reset while redirect_valid=1
    applyIdle();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_redirect_valid", 32'(bus.redirect_valid), 32'h0);
    checkOutput("async_rst_redirect_pc", bus.redirect_pc, 32'h0);
    lookup(32'h30);
    checkOutput("async_rst_f_hit_30", 32'(bus.f_hit), 32'h0);
    lookup(32'h200);
    checkOutput("async_rst_f_hit_200", 32'(bus.f_hit), 32'h0);
    lookup(32'h100);
    checkOutput("async_rst_f_hit_100", 32'(bus.f_hit), 32'h0);
    rst = 1'b0;
    clockStep();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
